// File: rtl/looping_player.sv
// Dual-clock sample playback buffer: samples written on w_clk, replayed in address order on r_clk.
// Optional multi-pass loop mode is built when LOOPING_PLAYER_LOOP_EN is defined.
module looping_player #(
  parameter int dataBits = 32,
  parameter int timeBits = 10,
  parameter int loopBits = 8
) (
  input  logic                r_clk,
  input  logic                r_reset_n,
  input  logic                r_start,
  input  logic                r_stop,
  input  logic [timeBits:0]   r_length,
  input  logic                r_loop,
  input  logic [loopBits-1:0] r_passes,
  output logic [dataBits-1:0] r_out,
  output logic                r_valid,
  output logic                r_last,
  output logic                r_busy,
  output logic                r_done,
  input  logic                w_clk,
  input  logic                w_enable,
  input  logic [timeBits-1:0] w_addr,
  input  logic [dataBits-1:0] w_in
);

  localparam int DEPTH = 2**timeBits;
  localparam logic [timeBits:0] DEPTH_L = (timeBits+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  logic [dataBits-1:0] r_mem [DEPTH];

  state_t              r_state, w_nextState;
  logic [timeBits-1:0] r_addr, w_nextAddr;
  logic [timeBits:0]   r_len, w_nextLen;
  logic                r_ending, w_nextEnding;
  logic                w_nextValid, w_nextLast, w_nextDone;
  logic                w_rdEn, w_load, w_passEnd, w_finalPass;
  logic [timeBits:0]   w_effLen;
  logic                w_atEnd;

  always_ff @(posedge w_clk) begin
    if (w_enable) r_mem[w_addr] <= w_in;
  end

  always_ff @(posedge r_clk) begin
    if (!r_reset_n) r_out <= '0;
    else if (w_rdEn) r_out <= r_mem[r_addr];
  end

  assign w_effLen = (r_length > DEPTH_L) ? DEPTH_L : r_length;
  assign w_atEnd  = ({1'b0, r_addr} == (r_len - 1'b1));
  assign r_busy   = (r_state == PLAY);

`ifdef LOOPING_PLAYER_LOOP_EN
  logic                r_loopMode;
  logic [loopBits-1:0] r_passCnt;

  // A pass count of zero in loop mode never reaches the final pass, so playback repeats forever.
  assign w_finalPass = !r_loopMode || (r_passCnt == loopBits'(1));

  always_ff @(posedge r_clk) begin
    if (!r_reset_n) begin
      r_loopMode <= 1'b0;
      r_passCnt  <= '0;
    end else if (w_load) begin
      r_loopMode <= r_loop;
      r_passCnt  <= r_passes;
    end else if (w_passEnd && r_loopMode && (r_passCnt != '0)) begin
      r_passCnt <= r_passCnt - 1'b1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_finalPass  = 1'b1;
  assign w_unused_cfg = ^{r_loop, r_passes, w_load, w_passEnd};
`endif

  always_comb begin
    w_nextState  = r_state;
    w_nextAddr   = r_addr;
    w_nextLen    = r_len;
    w_nextEnding = r_ending;
    w_nextValid  = r_valid;
    w_nextLast   = r_last;
    w_nextDone   = r_done;
    w_rdEn       = 1'b0;
    w_load       = 1'b0;
    w_passEnd    = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (r_start) begin
          w_load       = 1'b1;
          w_nextAddr   = '0;
          w_nextLen    = w_effLen;
          w_nextEnding = 1'b0;
          w_nextValid  = 1'b0;
          w_nextLast   = 1'b0;
          w_nextState  = (w_effLen == '0) ? DONE : PLAY;
          w_nextDone   = (w_effLen == '0);
        end
      end
      PLAY: begin
        if (r_stop || (r_ending && !r_start)) begin
          w_nextState  = DONE;
          w_nextValid  = 1'b0;
          w_nextLast   = 1'b0;
          w_nextDone   = 1'b1;
          w_nextEnding = 1'b0;
        end else if (r_start) begin
          w_load       = 1'b1;
          w_nextAddr   = '0;
          w_nextLen    = w_effLen;
          w_nextEnding = 1'b0;
          w_nextValid  = 1'b0;
          w_nextLast   = 1'b0;
          w_nextState  = (w_effLen == '0) ? DONE : PLAY;
          w_nextDone   = (w_effLen == '0);
        end else begin
          // The final read of the last pass only arms r_ending; DONE follows one edge later.
          w_rdEn      = 1'b1;
          w_nextValid = 1'b1;
          if (w_atEnd) begin
            w_nextLast = 1'b1;
            w_nextAddr = '0;
            if (w_finalPass) w_nextEnding = 1'b1;
            else w_passEnd = 1'b1;
          end else begin
            w_nextLast = 1'b0;
            w_nextAddr = r_addr + 1'b1;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!r_reset_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_ending <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_addr   <= w_nextAddr;
      r_len    <= w_nextLen;
      r_ending <= w_nextEnding;
      r_valid  <= w_nextValid;
      r_last   <= w_nextLast;
      r_done   <= w_nextDone;
    end
  end

endmodule

// File: tb/tb_looping_player.sv
// Directed self-checking bench for looping_player; expectations adapt to LOOPING_PLAYER_LOOP_EN.
module tb_looping_player;

  logic        r_clk = 1'b0;
  logic        w_clk = 1'b0;
  logic        r_reset_n;
  logic        r_start, r_stop, r_loop;
  logic [10:0] r_length;
  logic [7:0]  r_passes;
  logic [31:0] r_out;
  logic        r_valid, r_last, r_busy, r_done;
  logic        w_enable;
  logic [9:0]  w_addr;
  logic [31:0] w_in;

  int passCount = 0;
  int checkCount = 0;
  logic [31:0] model [1024];

  looping_player #(.dataBits(32), .timeBits(10), .loopBits(8)) dut (
    .r_clk(r_clk), .r_reset_n(r_reset_n), .r_start(r_start), .r_stop(r_stop),
    .r_length(r_length), .r_loop(r_loop), .r_passes(r_passes),
    .r_out(r_out), .r_valid(r_valid), .r_last(r_last), .r_busy(r_busy), .r_done(r_done),
    .w_clk(w_clk), .w_enable(w_enable), .w_addr(w_addr), .w_in(w_in)
  );

  always #7 r_clk = ~r_clk;
  always #3 w_clk = ~w_clk;

  task automatic tick;
    @(posedge r_clk);
    #1;
  endtask

  task automatic writeWord(input int a, input logic [31:0] d);
    @(negedge w_clk);
    w_enable = 1'b1;
    w_addr   = 10'(a);
    w_in     = d;
    @(posedge w_clk);
    #1;
    w_enable = 1'b0;
    model[a] = d;
  endtask

  task automatic startPlay(input logic [10:0] len, input logic lp, input logic [7:0] np);
    r_length = len;
    r_loop   = lp;
    r_passes = np;
    r_start  = 1'b1;
    tick();
    r_start  = 1'b0;
  endtask

  task automatic test_reset;
    r_reset_n = 1'b0;
    tick();
    tick();
    checkCount++;
    if ({r_valid, r_last, r_busy, r_done, r_out} !== 36'h0)
      $display("[TB] FAIL reset_state got %h want %h", {r_valid, r_last, r_busy, r_done, r_out}, 36'h0);
    else passCount++;
    r_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_depth;
    startPlay(11'd1024, 1'b0, 8'd0);
    for (int k = 1; k <= 1024; k++) begin
      tick();
      checkCount++;
      if ({r_valid, r_busy, r_last, r_done, r_out} !== {1'b1, 1'b1, (k == 1024), 1'b0, 32'h100 + 32'(k - 1)})
        $display("[TB] FAIL full_sample%0d got v%b b%b l%b d%b %h want out %h last %b",
                 k, r_valid, r_busy, r_last, r_done, r_out, 32'h100 + 32'(k - 1), (k == 1024));
      else passCount++;
    end
    tick();
    checkCount++;
    if ({r_valid, r_busy, r_last, r_done, r_out} !== {4'b0001, 32'h000004FF})
      $display("[TB] FAIL full_done got v%b b%b l%b d%b %h want v0 b0 l0 d1 000004ff",
               r_valid, r_busy, r_last, r_done, r_out);
    else passCount++;
  endtask

  task automatic test_short_loop;
`ifdef LOOPING_PLAYER_LOOP_EN
    int n = 6;
`else
    int n = 3;
`endif
    startPlay(11'd3, 1'b1, 8'd2);
    for (int k = 1; k <= n; k++) begin
      tick();
      checkCount++;
      if ({r_valid, r_busy, r_last, r_out} !== {1'b1, 1'b1, (k % 3 == 0), 32'h100 + 32'((k - 1) % 3)})
        $display("[TB] FAIL loop_sample%0d got v%b b%b l%b %h want %h last %b",
                 k, r_valid, r_busy, r_last, r_out, 32'h100 + 32'((k - 1) % 3), (k % 3 == 0));
      else passCount++;
    end
    tick();
    checkCount++;
    if ({r_valid, r_busy, r_last, r_done, r_out} !== {4'b0001, 32'h00000102})
      $display("[TB] FAIL loop_done got v%b b%b l%b d%b %h want v0 b0 l0 d1 00000102",
               r_valid, r_busy, r_last, r_done, r_out);
    else passCount++;
  endtask

  task automatic test_stop_restart;
`ifdef LOOPING_PLAYER_LOOP_EN
    int stopAt = 6;
`else
    int stopAt = 2;
`endif
    startPlay(11'd4, 1'b1, 8'd0);
    for (int k = 1; k <= stopAt; k++) begin
      tick();
      checkCount++;
      if ({r_valid, r_last, r_out} !== {1'b1, (k % 4 == 0), 32'h100 + 32'((k - 1) % 4)})
        $display("[TB] FAIL inf_sample%0d got v%b l%b %h want %h", k, r_valid, r_last, r_out,
                 32'h100 + 32'((k - 1) % 4));
      else passCount++;
    end
    r_stop = 1'b1;
    tick();
    r_stop = 1'b0;
    checkCount++;
    if ({r_valid, r_busy, r_done} !== 3'b001)
      $display("[TB] FAIL stop got v%b b%b d%b want v0 b0 d1", r_valid, r_busy, r_done);
    else passCount++;

    startPlay(11'd4, 1'b0, 8'd0);
    tick();
    tick();
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    tick();
    checkCount++;
    if ({r_valid, r_busy, r_done, r_out} !== {3'b110, 32'h00000100})
      $display("[TB] FAIL restart got v%b b%b d%b %h want v1 b1 d0 00000100", r_valid, r_busy, r_done, r_out);
    else passCount++;

    r_start = 1'b1;
    r_stop  = 1'b1;
    tick();
    r_start = 1'b0;
    r_stop  = 1'b0;
    tick();
    checkCount++;
    if ({r_valid, r_busy, r_done, r_out} !== {3'b001, 32'h00000100})
      $display("[TB] FAIL stop_beats_start got v%b b%b d%b %h want v0 b0 d1 00000100",
               r_valid, r_busy, r_done, r_out);
    else passCount++;
  endtask

  task automatic test_edge_lengths;
    int cnt = 0;
    bit finished = 0;
    logic [31:0] lastOut = '0;
    r_reset_n = 1'b0;
    tick();
    r_reset_n = 1'b1;
    startPlay(11'd0, 1'b0, 8'd0);
    tick();
    checkCount++;
    if ({r_valid, r_busy, r_done} !== 3'b001)
      $display("[TB] FAIL zero_len got v%b b%b d%b want v0 b0 d1", r_valid, r_busy, r_done);
    else passCount++;

    startPlay(11'd1029, 1'b0, 8'd0);
    for (int c = 0; c < 1100 && !finished; c++) begin
      tick();
      if (r_valid) begin
        cnt++;
        lastOut = r_out;
      end
      if (r_done) finished = 1;
    end
    checkCount++;
    if (!finished) $display("[TB] FAIL clamp_timeout got done 0 want done 1 within 1100 cycles");
    else passCount++;
    checkCount++;
    if (cnt !== 1024) $display("[TB] FAIL clamp_count got %0d want 1024", cnt);
    else passCount++;
    checkCount++;
    if (lastOut !== 32'h000004FF) $display("[TB] FAIL clamp_last got %h want 000004ff", lastOut);
    else passCount++;
  endtask

  task automatic test_reset_mid;
    startPlay(11'd20, 1'b0, 8'd0);
    for (int k = 1; k <= 10; k++) tick();
    checkCount++;
    if ({r_valid, r_out} !== {1'b1, 32'h00000109})
      $display("[TB] FAIL mid_sample10 got v%b %h want v1 00000109", r_valid, r_out);
    else passCount++;
    r_reset_n = 1'b0;
    tick();
    checkCount++;
    if ({r_valid, r_last, r_busy, r_done, r_out} !== 36'h0)
      $display("[TB] FAIL mid_reset got %h want %h", {r_valid, r_last, r_busy, r_done, r_out}, 36'h0);
    else passCount++;
    r_reset_n = 1'b1;
    startPlay(11'd20, 1'b0, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkCount++;
      if ({r_valid, r_out} !== {1'b1, 32'h100 + 32'(k - 1)})
        $display("[TB] FAIL replay_sample%0d got v%b %h want v1 %h", k, r_valid, r_out, 32'h100 + 32'(k - 1));
      else passCount++;
    end
  endtask

  task automatic test_async_writes;
    logic [31:0] exp;
    startPlay(11'd21, 1'b0, 8'd0);
    fork
      begin
        for (int i = 50; i <= 60; i++) writeWord(i, 32'hA0000000 + 32'(i));
      end
      begin
        for (int k = 1; k <= 21; k++) begin
          tick();
          checkCount++;
          if ({r_valid, r_out} !== {1'b1, 32'h100 + 32'(k - 1)})
            $display("[TB] FAIL async_sample%0d got v%b %h want v1 %h", k, r_valid, r_out, 32'h100 + 32'(k - 1));
          else passCount++;
        end
      end
    join
    tick();
    startPlay(11'd61, 1'b0, 8'd0);
    for (int k = 1; k <= 61; k++) begin
      tick();
      exp = (k - 1 >= 50) ? 32'hA0000000 + 32'(k - 1) : 32'h100 + 32'(k - 1);
      checkCount++;
      if ({r_valid, r_out} !== {1'b1, exp})
        $display("[TB] FAIL rewritten_sample%0d got v%b %h want v1 %h", k, r_valid, r_out, exp);
      else passCount++;
    end
  endtask

  initial begin
    r_reset_n = 1'b0;
    r_start   = 1'b0;
    r_stop    = 1'b0;
    r_loop    = 1'b0;
    r_length  = '0;
    r_passes  = '0;
    w_enable  = 1'b0;
    w_addr    = '0;
    w_in      = '0;
    test_reset();
    for (int i = 0; i < 1024; i++) writeWord(i, 32'h100 + 32'(i));
    test_full_depth();
    test_short_loop();
    test_stop_restart();
    test_edge_lengths();
    test_reset_mid();
    test_async_writes();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
